// File: rtl/cache_pkg.sv
// Shared cache-subsystem definitions: arbiter FSM states, bus width defaults
// and the requester indices used by the instruction and data caches.
package cache_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  function automatic logic [1:0] req_onehot(input logic idx);
    logic [1:0] vec;
    case (idx)
      ICACHE:  vec = 2'b01;
      DCACHE:  vec = 2'b10;
      default: vec = 2'b00;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and main-memory signals of the arbiter. The master modport is the
// arbiter's view; the slave modport is the caches/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_ready;

  modport master (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_data_out, mem_ready,
    output done, err, rdata, mem_address, mem_data_in, mem_read, mem_write
  );

  modport slave (
    output req, we, addr0, addr1, wdata0, wdata1, mem_data_out, mem_ready,
    input  done, err, rdata, mem_address, mem_data_in, mem_read, mem_write
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a tie goes to the requester that
// was not granted last.
module rr_arb2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  // Pick the sole requester, or the one that did not win last time.
  always_comb begin
    gnt_idx   = ICACHE;
    gnt_valid = 1'b0;
    case (req)
      2'b01: begin
        gnt_idx   = ICACHE;
        gnt_valid = 1'b1;
      end
      2'b10: begin
        gnt_idx   = DCACHE;
        gnt_valid = 1'b1;
      end
      2'b11: begin
        gnt_idx   = ~last;
        gnt_valid = 1'b1;
      end
      default: begin
        gnt_idx   = ICACHE;
        gnt_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction- and data-cache transactions onto the single memory
// port, one at a time, with a watchdog that aborts unacknowledged accesses.
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int             WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_e        state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] data_in_r, data_in_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              read_r, read_s;
  logic              write_r, write_s;
  logic [1:0]        done_r, done_s;
  logic              err_r, err_s;
  logic              last_r, last_s;
  logic [WD_W-1:0]   wd_r, wd_s;
  logic              gnt_idx_s;
  logic              gnt_valid_s;

  rr_arb2 u_rr_arb2 (
    .req       (bus.req),
    .last      (last_r),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Next-state and next-output computation; last_r doubles as the current winner.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    data_in_s = data_in_r;
    rdata_s   = rdata_r;
    read_s    = read_r;
    write_s   = write_r;
    done_s    = done_r;
    err_s     = err_r;
    last_s    = last_r;
    wd_s      = wd_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          last_s    = gnt_idx_s;
          addr_s    = (gnt_idx_s == DCACHE) ? bus.addr1 : bus.addr0;
          data_in_s = (gnt_idx_s == DCACHE) ? bus.wdata1 : bus.wdata0;
          read_s    = ~bus.we[gnt_idx_s];
          write_s   = bus.we[gnt_idx_s];
          wd_s      = '0;
          state_s   = ISSUE;
        end else begin
          state_s   = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          if (read_r) begin
            rdata_s = bus.mem_data_out;
          end else begin
            rdata_s = rdata_r;
          end
          read_s  = 1'b0;
          write_s = 1'b0;
          done_s  = req_onehot(last_r);
          state_s = RESP;
        end else if (wd_r == WD_LAST) begin
          read_s  = 1'b0;
          write_s = 1'b0;
          done_s  = req_onehot(last_r);
          err_s   = 1'b1;
          state_s = RESP;
        end else begin
          wd_s    = wd_r + WD_W'(1);
        end
      end
      RESP: begin
        done_s  = 2'b00;
        err_s   = 1'b0;
        state_s = IDLE;
      end
      default: begin
        read_s  = 1'b0;
        write_s = 1'b0;
        done_s  = 2'b00;
        err_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      data_in_r <= '0;
      rdata_r   <= '0;
      read_r    <= 1'b0;
      write_r   <= 1'b0;
      done_r    <= 2'b00;
      err_r     <= 1'b0;
      last_r    <= DCACHE;
      wd_r      <= '0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      data_in_r <= data_in_s;
      rdata_r   <= rdata_s;
      read_r    <= read_s;
      write_r   <= write_s;
      done_r    <= done_s;
      err_r     <= err_s;
      last_r    <= last_s;
      wd_r      <= wd_s;
    end
  end

  assign bus.done        = done_r;
  assign bus.err         = err_r;
  assign bus.rdata       = rdata_r;
  assign bus.mem_address = addr_r;
  assign bus.mem_data_in = data_in_r;
  assign bus.mem_read    = read_r;
  assign bus.mem_write   = write_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction table plus hand-written
// sequences for contention, timeout, latched requests and async reset.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_t ();

  mem_arbiter #(.TIMEOUT(64), .ADDR_W(32), .DATA_W(32)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mem_arbiter #(.TIMEOUT(4), .ADDR_W(32), .DATA_W(32)) dut_t (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] mrd;
    int          delay;
    logic [1:0]  exp_done;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on dut_a, starting and ending in IDLE at #1 past an edge.
  task automatic run_txn(input vec_t v, input string tag);
    bus_a.req    = v.req;
    bus_a.we     = v.we;
    bus_a.addr0  = v.addr0;
    bus_a.addr1  = v.addr1;
    bus_a.wdata0 = v.wdata0;
    bus_a.wdata1 = v.wdata1;
    bus_a.mem_ready = 1'b0;
    tick();
    chk({tag, " issue_addr"}, bus_a.mem_address, v.exp_addr);
    chk({tag, " issue_wdata"}, bus_a.mem_data_in, v.exp_wdata);
    chk({tag, " issue_rd"}, bus_a.mem_read, v.exp_rd);
    chk({tag, " issue_wr"}, bus_a.mem_write, v.exp_wr);
    for (int i = 0; i < v.delay; i++) begin
      tick();
      chk({tag, " wait_strobe"}, {bus_a.mem_read, bus_a.mem_write}, {v.exp_rd, v.exp_wr});
      chk({tag, " wait_addr"}, bus_a.mem_address, v.exp_addr);
    end
    bus_a.mem_ready    = 1'b1;
    bus_a.mem_data_out = v.mrd;
    tick();
    bus_a.mem_ready = 1'b0;
    chk({tag, " done"}, bus_a.done, v.exp_done);
    chk({tag, " err"}, bus_a.err, 1'b0);
    chk({tag, " rdata"}, bus_a.rdata, v.exp_rdata);
    chk({tag, " strobes_off"}, {bus_a.mem_read, bus_a.mem_write}, 2'b00);
    bus_a.req = 2'b00;
    tick();
    chk({tag, " done_clear"}, bus_a.done, 2'b00);
  endtask

  initial begin
    vec_t v;
    logic exp_w;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus_a.req = 2'b00; bus_a.we = 2'b00; bus_a.addr0 = '0; bus_a.addr1 = '0;
    bus_a.wdata0 = '0; bus_a.wdata1 = '0; bus_a.mem_data_out = '0; bus_a.mem_ready = 1'b0;
    bus_t.req = 2'b00; bus_t.we = 2'b00; bus_t.addr0 = '0; bus_t.addr1 = '0;
    bus_t.wdata0 = '0; bus_t.wdata1 = '0; bus_t.mem_data_out = '0; bus_t.mem_ready = 1'b0;

    // req, we, addr0, addr1, wdata0, wdata1, mrd, delay, done, addr, wdata, rdata, rd, wr
    vecs[0] = '{2'b01, 2'b00, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                32'hDEAD_BEEF, 0, 2'b01, 32'h0000_0400, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[1] = '{2'b10, 2'b10, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'hA5A5_A5A5,
                32'h1111_1111, 5, 2'b10, 32'h1234_5678, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 2'b00, 32'h0000_0100, 32'h0000_0200, 32'h0000_0011, 32'h0000_0022,
                32'hCAFE_0001, 1, 2'b01, 32'h0000_0100, 32'h0000_0011, 32'hCAFE_0001, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 2'b01, 32'h0000_0100, 32'h0000_0200, 32'h0000_0011, 32'h0000_0022,
                32'h0BAD_F00D, 0, 2'b10, 32'h0000_0200, 32'h0000_0022, 32'h0BAD_F00D, 1'b1, 1'b0};
    vecs[4] = '{2'b11, 2'b11, 32'h0000_0100, 32'h0000_0200, 32'h5555_AAAA, 32'h0000_0022,
                32'h7777_7777, 2, 2'b01, 32'h0000_0100, 32'h5555_AAAA, 32'h0BAD_F00D, 1'b0, 1'b1};
    vecs[5] = '{2'b01, 2'b00, 32'hFFFF_FFFC, 32'h0000_0200, 32'h0000_0001, 32'h0000_0022,
                32'h8000_0001, 2, 2'b01, 32'hFFFF_FFFC, 32'h0000_0001, 32'h8000_0001, 1'b1, 1'b0};

    tick();
    chk("rst done", bus_a.done, 2'b00);
    chk("rst err", bus_a.err, 1'b0);
    chk("rst rdata", bus_a.rdata, 32'h0);
    chk("rst strobes", {bus_a.mem_read, bus_a.mem_write}, 2'b00);
    chk("rst addr", bus_a.mem_address, 32'h0);
    chk("rst data_in", bus_a.mem_data_in, 32'h0);
    #2;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Contention: last winner was 0, so grants go 1,0,1,0 every 3 cycles.
    bus_a.req = 2'b11; bus_a.we = 2'b00;
    bus_a.addr0 = 32'h0000_00A0; bus_a.addr1 = 32'h0000_00B0;
    bus_a.mem_ready = 1'b1; bus_a.mem_data_out = 32'h0000_0C0C;
    exp_w = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d addr", k), bus_a.mem_address, exp_w ? 32'h0000_00B0 : 32'h0000_00A0);
      chk($sformatf("rr%0d rd", k), bus_a.mem_read, 1'b1);
      tick();
      chk($sformatf("rr%0d done", k), bus_a.done, exp_w ? 2'b10 : 2'b01);
      tick();
      chk($sformatf("rr%0d gap", k), bus_a.done, 2'b00);
      exp_w = ~exp_w;
    end
    bus_a.req = 2'b00;

    // mem_ready while idle must be ignored.
    tick();
    chk("idle_ready done", bus_a.done, 2'b00);
    tick();
    chk("idle_ready rd", bus_a.mem_read, 1'b0);
    bus_a.mem_ready = 1'b0;

    // Request and address change after the grant do not disturb the transaction.
    bus_a.req = 2'b01; bus_a.we = 2'b00; bus_a.addr0 = 32'h0000_0800;
    tick();
    bus_a.req = 2'b00; bus_a.addr0 = 32'h0000_0C00; bus_a.we = 2'b01;
    tick();
    chk("latch addr", bus_a.mem_address, 32'h0000_0800);
    chk("latch rd", bus_a.mem_read, 1'b1);
    bus_a.mem_ready = 1'b1; bus_a.mem_data_out = 32'h1357_9BDF;
    tick();
    bus_a.mem_ready = 1'b0;
    chk("latch done", bus_a.done, 2'b01);
    chk("latch rdata", bus_a.rdata, 32'h1357_9BDF);
    chk("latch addr_hold", bus_a.mem_address, 32'h0000_0800);
    tick();
    bus_a.we = 2'b00;

    // Timeout on the TIMEOUT=4 instance.
    bus_t.req = 2'b01; bus_t.addr0 = 32'h0000_0044;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("to cyc%0d rd", c), bus_t.mem_read, 1'b1);
      chk($sformatf("to cyc%0d done", c), bus_t.done, 2'b00);
    end
    tick();
    chk("to done", bus_t.done, 2'b01);
    chk("to err", bus_t.err, 1'b1);
    chk("to rd_off", bus_t.mem_read, 1'b0);
    bus_t.req = 2'b00;
    tick();
    chk("to idle done", bus_t.done, 2'b00);
    chk("to idle err", bus_t.err, 1'b0);

    // Async reset mid-transaction; last returns to 1 so a tie then goes to 0.
    bus_a.req = 2'b01; bus_a.we = 2'b00; bus_a.addr0 = 32'h0000_0040;
    tick();
    chk("ar rd_before", bus_a.mem_read, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar rd_now", bus_a.mem_read, 1'b0);
    chk("ar addr_now", bus_a.mem_address, 32'h0);
    bus_a.req = 2'b00;
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick();
    chk("ar no_done", bus_a.done, 2'b00);
    chk("ar idle_rd", bus_a.mem_read, 1'b0);
    v = '{2'b11, 2'b00, 32'h0000_0010, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000,
          32'h2468_ACE0, 0, 2'b01, 32'h0000_0010, 32'h0000_0000, 32'h2468_ACE0, 1'b1, 1'b0};
    run_txn(v, "ar_tie");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single main-memory port between two cache controllers: requester 0 is the instruction cache and requester 1 is the data cache. It sits between the caches' miss/write-back interfaces and main memory. It serialises one memory transaction at a time, using round-robin priority and a level-request/pulse-done handshake. A watchdog aborts transactions that memory never acknowledges.

## Interface
- `TIMEOUT`, default 64: cycles to wait for `mem_ready` before aborting; must be ≥ 2.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk` — in, 1: single clock, rising edge.
- `reset` — in, 1: asynchronous, active-high; clears all state and outputs immediately.
- `req[1:0]` — in, 2: per-requester level request.
- `we[1:0]` — in, 2: per-requester write enable (1 = write, 0 = read).
- `addr0`, `addr1` — in, ADDR_W: request addresses.
- `wdata0`, `wdata1` — in, DATA_W: write data.
- `done[1:0]` — out, 2: one-cycle completion pulse per requester.
- `err` — out, 1: qualifies `done`; high means the transaction timed out.
- `rdata` — out, DATA_W: read data, valid while any `done` bit is high.
- `mem_address` — out, ADDR_W: memory address.
- `mem_data_in` — out, DATA_W: data to memory.
- `mem_read` — out, 1: memory read strobe.
- `mem_write` — out, 1: memory write strobe.
- `mem_data_out` — in, DATA_W: data from memory.
- `mem_ready` — in, 1: memory completes the current access in this cycle.

## Operation
- **FSM states:** IDLE, ISSUE, RESP.
- **Reset values:** state = IDLE; `done` = 0; `err` = 0; `rdata` = 0; `mem_read` = 0; `mem_write` = 0; `mem_address` = 0; `mem_data_in` = 0; `last` = 1, so requester 0 wins the first tie; watchdog = 0.
- **IDLE:**
  - If any `req` bit is high, choose the winner: the sole requester, or on a tie the requester that is not `last`.
  - Latch the winner's addr, wdata and we into `mem_address` and `mem_data_in`.
  - Set `mem_read = ~we` and `mem_write = we`.
  - Set `last` to the winner, clear the watchdog, and go to ISSUE.
- **ISSUE:**
  - Strobes and address are held constant.
  - If `mem_ready`: capture `mem_data_out` into `rdata` (reads only; on writes `rdata` keeps its old value), drop the strobes, assert `done[winner]`, and go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT−1 without `mem_ready`: drop the strobes, assert `done[winner]` and `err`, and go to RESP.
- **RESP:** lasts exactly one cycle with `done` (and possibly `err`) high, then returns to IDLE and clears `done` and `err`.
- **Latched request:** after the grant, changes on req, addr, wdata or we do not affect the transaction in flight.
  - A requester that drops `req` mid-transaction still receives its `done` pulse.
- **Requester obligation:** drop `req` at the clock edge that ends the RESP cycle in which it saw `done`. A `req` still high in the following IDLE cycle is treated as a new request.
- **Ignored requests:** `req` is not sampled in ISSUE or RESP.
- **Illegal memory behaviour:** `mem_ready` seen in IDLE or RESP is ignored.
- **Reset mid-transaction:** strobes drop asynchronously and no `done` is issued. Requesters must treat reset as an abort.

## Timing
- **Grant:** `req` sampled at edge E0 in IDLE → strobes and address are registered high from E0 and visible in cycle 1.
- **Best-case latency:** `mem_ready` high in cycle 1 → RESP in cycle 2 → `done` in cycle 2, 2 cycles after E0.
  - In general, `mem_ready` first high in cycle k gives `done` in cycle k+1.
- **Throughput:** the minimum inter-transaction period is 3 cycles (IDLE, ISSUE, RESP). Back-to-back grants alternate requesters when both hold `req`.
- **Timeout:** `mem_ready` never asserted → `done` and `err` in cycle TIMEOUT+1 after E0. Strobes are high for exactly TIMEOUT cycles.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `cache_pkg`:** the state enum (IDLE/ISSUE/RESP), ADDR_W/DATA_W defaults, and the requester index constants (ICACHE = 0, DCACHE = 1). The same package is used by the cache controllers.
- **Sub-module `rr_arb2`:** combinational 2-way round-robin picker. It takes `req[1:0]` and `last` and returns `gnt_idx` and `gnt_valid`. The FSM, latches and watchdog stay in `mem_arbiter`.

## Test plan
- **Single read:** `req` = 01, addr0 = 0x0000_0400, `mem_ready` in cycle 1 with `mem_data_out` = 0xDEAD_BEEF → `mem_read` high in cycle 1; `done` = 01 and `rdata` = 0xDEAD_BEEF in cycle 2; `err` = 0.
- **Contention:** `req` = 11 held, with immediate `mem_ready` → grants alternate 0,1,0,1 after the first winner. Each requester then drops `req` on its `done`; no requester gets two consecutive grants.
- **Write from requester 1:** we1 = 1, addr1 = 0x1234_5678, wdata1 = 0xA5A5_A5A5, with `mem_ready` after 5 wait cycles → `mem_write` high for 6 cycles with stable address and data; `done` = 10; `rdata` unchanged.
- **Timeout with TIMEOUT = 4:** `mem_ready` held low → strobes high for 4 cycles; `done` and `err` high in cycle 5; back in IDLE in cycle 6.
- **Mid-transaction changes:** addr0 changed and `req` dropped while in ISSUE → `mem_address` holds the original value and `done[0]` still pulses.
- **Asynchronous reset mid-transaction:** reset asserted between edges while in ISSUE → `mem_read` and `mem_write` go low immediately. After release, state is IDLE, with no `done` and `last` = 1.
